// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_t;

    localparam int unsigned DATA_BITS   = 8;
    localparam int unsigned MIN_DIVISOR = 2;
    localparam int unsigned DIV_W       = 12;

    // Divisors below the minimum would leave no room for a bit period.
    function automatic logic [DIV_W-1:0] clamp_divisor(input logic [DIV_W-1:0] div);
        return (div < DIV_W'(MIN_DIVISOR)) ? DIV_W'(MIN_DIVISOR) : div;
    endfunction

endpackage

// File: rtl/tx_baud_counter.sv
// Bit-period timer: pulses tick on the last clock of each bit period.
module tx_baud_counter
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    input  logic [DIV_W-1:0] divisor,
    output logic             tick
);

    logic [DIV_W-1:0] count_q, count_d;
    logic [DIV_W-1:0] last_count;

    assign last_count = divisor - DIV_W'(1);
    assign tick       = !restart && (count_q == last_count);

    always_comb begin
        count_d = count_q + DIV_W'(1);
        if (restart || tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter with a transmit FIFO; 8 data bits, optional even parity, 1 or 2 stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] baud_divisor,
    input  logic             parity_en,
    input  logic             two_stop_bits,
    input  logic [7:0]       tx_data,
    input  logic             wr_en,
    output logic             tx_out,
    output logic             tx_busy,
    output logic             tx_done,
    output logic             fifo_full,
    output logic             fifo_empty,
    output logic             overflow
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned BIT_W = $clog2(DATA_BITS);

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 push, pop;

    tx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 par_en_q, par_en_d;
    logic                 two_stop_q, two_stop_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 tx_out_q, tx_out_d;
    logic                 overflow_q, overflow_d;
    logic                 tick, restart, last_stop;

    // ---------------- FIFO ----------------
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = wr_en && !fifo_full;
    assign pop        = (state_q == StIdle) && !fifo_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    // ---------------- Bit timing ----------------
    assign restart = (state_q == StIdle);

    tx_baud_counter u_baud (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .divisor (div_q),
        .tick    (tick)
    );

    // ---------------- State register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= StIdle;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            div_q      <= DIV_W'(MIN_DIVISOR);
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_out_q   <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            par_en_q   <= par_en_d;
            two_stop_q <= two_stop_d;
            div_q      <= div_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_out_q   <= tx_out_d;
            overflow_q <= overflow_d;
        end
    end

    // ---------------- Next state ----------------
    assign last_stop = !(two_stop_q && !stop_cnt_q);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        par_en_d   = par_en_q;
        two_stop_d = two_stop_q;
        div_d      = div_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        unique case (state_q)
            StIdle: begin
                // Frame configuration is frozen here for the whole frame.
                if (pop) begin
                    state_d    = StStart;
                    shift_d    = mem_q[rd_ptr_q];
                    parity_d   = ^mem_q[rd_ptr_q];
                    par_en_d   = parity_en;
                    two_stop_d = two_stop_bits;
                    div_d      = clamp_divisor(baud_divisor);
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                end
            end
            StStart: begin
                if (tick) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (tick) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                        state_d = par_en_q ? StParity : StStop;
                    end
                end
            end
            StParity: begin
                if (tick) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (tick) begin
                    if (last_stop) begin
                        state_d = StIdle;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ---------------- Outputs ----------------
    // tx_out is registered from the upcoming state so the line changes exactly on bit boundaries.
    always_comb begin
        tx_out_d = 1'b1;
        unique case (state_d)
            StStart:  tx_out_d = 1'b0;
            StData:   tx_out_d = shift_d[0];
            StParity: tx_out_d = parity_d;
            default:  tx_out_d = 1'b1;
        endcase
        overflow_d = wr_en && fifo_full;
    end

    assign tx_out   = tx_out_q;
    assign tx_busy  = (state_q != StIdle);
    assign tx_done  = (state_q == StStop) && tick && last_stop;
    assign overflow = overflow_q;

endmodule
